tour_cmd: RTL and testbench

TOUR_CMD -- requirements
Module: tour_cmd

---
 rtl/knight_pkg.sv | 37 +++
 rtl/tour_cmd_if.sv | 26 ++
 rtl/tour_cmd.sv | 141 ++++++++++++++
 tb/tb_tour_cmd.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
// Shared knight-tour definitions: FSM states, command opcodes, headings,
// response codes and the tour length.
// Latency: n/a (types and constants only). Backpressure: n/a.
package knight_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VERT      = 3'd1,
    VERT_WAIT = 3'd2,
    HORZ      = 3'd3,
    HORZ_WAIT = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVE         = 4'h4;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h5;

  localparam logic [7:0] HEAD_NORTH = 8'h00;
  localparam logic [7:0] HEAD_SOUTH = 8'h7F;
  localparam logic [7:0] HEAD_EAST  = 8'hBF;
  localparam logic [7:0] HEAD_WEST  = 8'h3F;

  localparam logic [7:0] RESP_BUSY = 8'hA5;
  localparam logic [7:0] RESP_DONE = 8'h5A;

  localparam int         NUM_MOVES = 24;
  localparam logic [4:0] LAST_MOVE = 5'(NUM_MOVES - 1);

  // One decoded L-move split into its two straight legs.
  typedef struct packed {
    logic       vld;      // at least one move bit was set
    logic       x_east;   // horizontal leg points east
    logic [3:0] x_sq;     // horizontal leg length in squares
    logic       y_north;  // vertical leg points north
    logic [3:0] y_sq;     // vertical leg length in squares
  } move_dec_t;

endpackage

// File: rtl/tour_cmd_if.sv
// Bundle between tour_cmd, the move store, the UART wrapper and the command processor.
// Latency: n/a (wires only). Backpressure: cmd_rdy/clr_cmd_rdy/send_resp handshake.
// slave = tour_cmd side, master = environment side (move store, UART, consumer).
interface tour_cmd_if;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic [7:0]  resp;

  modport slave (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, clr_cmd_rdy_UART, resp
  );

  modport master (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, clr_cmd_rdy_UART, resp
  );
endinterface

// File: rtl/tour_cmd.sv
// Plays back a stored knight's tour as vertical/horizontal move commands; passes UART cmds when idle.
// Latency: tour cmd registered, valid the cycle after start_tour / send_resp.
// Backpressure: each cmd held until clr_cmd_rdy, next cmd only after send_resp.
// Ports: clk, rst (sync, active-high); bus (tour_cmd_if.slave): start_tour, move, mv_indx,
//        cmd_UART/cmd_rdy_UART/clr_cmd_rdy_UART (UART side), cmd/cmd_rdy/clr_cmd_rdy/send_resp (consumer), resp.
module tour_cmd
  import knight_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  tour_cmd_if.slave  bus
);

  state_t      r_state;
  logic [4:0]  r_mv_indx;
  logic [15:0] r_cmd;
  logic        r_rdy;
  logic [7:0]  r_resp;

  move_dec_t   w_dec;
  logic [15:0] w_vcmd;
  logic [15:0] w_hcmd;
  logic        w_start;
  logic        w_advance;
  logic [4:0]  w_rd_indx;

  // Lowest set bit wins when the move byte is multi-hot.
  function automatic move_dec_t decode_move(input logic [7:0] mv);
    move_dec_t d;
    d     = '0;
    d.vld = |mv;
    casez (mv)
      8'b???????1: begin d.x_east = 1'b1; d.x_sq = 4'd1; d.y_north = 1'b1; d.y_sq = 4'd2; end
      8'b??????10: begin d.x_east = 1'b0; d.x_sq = 4'd1; d.y_north = 1'b1; d.y_sq = 4'd2; end
      8'b?????100: begin d.x_east = 1'b0; d.x_sq = 4'd2; d.y_north = 1'b1; d.y_sq = 4'd1; end
      8'b????1000: begin d.x_east = 1'b0; d.x_sq = 4'd2; d.y_north = 1'b0; d.y_sq = 4'd1; end
      8'b???10000: begin d.x_east = 1'b0; d.x_sq = 4'd1; d.y_north = 1'b0; d.y_sq = 4'd2; end
      8'b??100000: begin d.x_east = 1'b1; d.x_sq = 4'd1; d.y_north = 1'b0; d.y_sq = 4'd2; end
      8'b?1000000: begin d.x_east = 1'b1; d.x_sq = 4'd2; d.y_north = 1'b0; d.y_sq = 4'd1; end
      8'b10000000: begin d.x_east = 1'b1; d.x_sq = 4'd2; d.y_north = 1'b1; d.y_sq = 4'd1; end
      default:     d = '0;
    endcase
    return d;
  endfunction

  assign w_dec  = decode_move(bus.move);
  assign w_vcmd = {OP_MOVE,         (w_dec.y_north ? HEAD_NORTH : HEAD_SOUTH), w_dec.y_sq};
  assign w_hcmd = {OP_MOVE_FANFARE, (w_dec.x_east  ? HEAD_EAST  : HEAD_WEST),  w_dec.x_sq};

  assign w_start   = (r_state == IDLE) && bus.start_tour;
  assign w_advance = (r_state == HORZ_WAIT) && bus.send_resp && (r_mv_indx != LAST_MOVE);

  // The move store is read combinationally, so on the edge that enters VERT
  // the index must already point at the move being loaded: present the
  // upcoming index during that cycle, the registered one otherwise.
  always_comb begin
    w_rd_indx = r_mv_indx;
    if (w_start) begin
      w_rd_indx = 5'd0;
    end else if (w_advance) begin
      w_rd_indx = r_mv_indx + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mv_indx <= 5'd0;
      r_cmd     <= 16'h0000;
      r_rdy     <= 1'b0;
      r_resp    <= RESP_DONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_tour) begin
            r_mv_indx <= 5'd0;
            // An empty first move aborts before any command is offered.
            if (w_dec.vld) begin
              r_state <= VERT;
              r_cmd   <= w_vcmd;
              r_rdy   <= 1'b1;
              r_resp  <= RESP_BUSY;
            end
          end
        end
        VERT: begin
          if (bus.clr_cmd_rdy) begin
            r_state <= VERT_WAIT;
            r_rdy   <= 1'b0;
          end
        end
        VERT_WAIT: begin
          if (bus.send_resp) begin
            r_state <= HORZ;
            r_cmd   <= w_hcmd;
            r_rdy   <= 1'b1;
          end
        end
        HORZ: begin
          if (bus.clr_cmd_rdy) begin
            r_state <= HORZ_WAIT;
            r_rdy   <= 1'b0;
            // Final leg of the tour: report completion while it executes.
            if (r_mv_indx == LAST_MOVE) begin
              r_resp <= RESP_DONE;
            end
          end
        end
        HORZ_WAIT: begin
          if (bus.send_resp) begin
            if (r_mv_indx == LAST_MOVE) begin
              r_state <= IDLE;
            end else begin
              r_mv_indx <= w_rd_indx;
              if (w_dec.vld) begin
                r_state <= VERT;
                r_cmd   <= w_vcmd;
                r_rdy   <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_resp  <= RESP_DONE;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
          r_resp  <= RESP_DONE;
        end
      endcase
    end
  end

  assign bus.mv_indx          = w_rd_indx;
  assign bus.cmd              = (r_state == IDLE) ? bus.cmd_UART     : r_cmd;
  assign bus.cmd_rdy          = (r_state == IDLE) ? bus.cmd_rdy_UART : r_rdy;
  assign bus.clr_cmd_rdy_UART = (r_state == IDLE) && bus.clr_cmd_rdy;
  assign bus.resp             = r_resp;

endmodule

// File: tb/tb_tour_cmd.sv
module tb_tour_cmd;
  import knight_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        cmd_rdy_UART;
  logic [15:0] cmd_UART;
  logic [7:0]  mv_store [24];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tour_cmd_if bus();

  assign bus.start_tour   = start_tour;
  assign bus.clr_cmd_rdy  = clr_cmd_rdy;
  assign bus.send_resp    = send_resp;
  assign bus.cmd_rdy_UART = cmd_rdy_UART;
  assign bus.cmd_UART     = cmd_UART;
  assign bus.move         = (bus.mv_indx < 5'd24) ? mv_store[bus.mv_indx] : 8'h00;

  tour_cmd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: tour as a list of 48 steps ----------------
  function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input int horiz);
    int b;
    int dx;
    int dy;
    b = -1;
    for (int i = 7; i >= 0; i--) if (mv[i]) b = i;
    case (b)
      0: begin dx =  1; dy =  2; end
      1: begin dx = -1; dy =  2; end
      2: begin dx = -2; dy =  1; end
      3: begin dx = -2; dy = -1; end
      4: begin dx = -1; dy = -2; end
      5: begin dx =  1; dy = -2; end
      6: begin dx =  2; dy = -1; end
      7: begin dx =  2; dy =  1; end
      default: begin dx = 0; dy = 0; end
    endcase
    if (horiz == 0)
      return {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy > 0) ? dy : -dy)};
    else
      return {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx > 0) ? dx : -dx)};
  endfunction

  bit          m_on     = 1'b0;
  bit          m_active = 1'b0;
  bit          m_taken  = 1'b0;
  int          m_step   = 0;   // 0..47: even = vertical leg of move step/2, odd = horizontal
  logic [15:0] m_cmd    = 16'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_active = 1'b0; m_taken = 1'b0; m_step = 0;
    end else if (m_on) begin
      if (!m_active) begin
        if (start_tour && mv_store[0] != 8'h00) begin
          m_active = 1'b1; m_step = 0; m_taken = 1'b0;
          m_cmd = exp_cmd(mv_store[0], 0);
        end
      end else if (!m_taken) begin
        if (clr_cmd_rdy) m_taken = 1'b1;
      end else if (send_resp) begin
        if (m_step == 47) begin
          m_active = 1'b0;
        end else begin
          m_step++;
          m_taken = 1'b0;
          if (m_step % 2 == 0 && mv_store[m_step / 2] == 8'h00) m_active = 1'b0;
          else m_cmd = exp_cmd(mv_store[m_step / 2], m_step % 2);
        end
      end
    end
  end

  always @(negedge clk) begin
    int exp_idx;
    if (m_on) begin
      if (m_active) begin
        chk("cmd", 32'(bus.cmd), 32'(m_cmd));
        chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(!m_taken));
        chk("clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'd0);
        chk("resp", 32'(bus.resp), (m_taken && m_step == 47) ? 32'h5A : 32'hA5);
        exp_idx = m_step / 2;
        if (m_taken && send_resp && (m_step % 2 == 1) && m_step < 47) exp_idx++;
        chk("mv_indx", 32'(bus.mv_indx), 32'(exp_idx));
      end else begin
        chk("idle_cmd", 32'(bus.cmd), 32'(cmd_UART));
        chk("idle_rdy", 32'(bus.cmd_rdy), 32'(cmd_rdy_UART));
        chk("idle_clr", 32'(bus.clr_cmd_rdy_UART), 32'(clr_cmd_rdy));
        chk("idle_resp", 32'(bus.resp), 32'h5A);
        if (start_tour) chk("start_indx", 32'(bus.mv_indx), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_random();
    int r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 63);
      if (r == 0)     mv_store[i] = 8'h00;
      else if (r < 8) mv_store[i] = 8'($urandom_range(1, 255));
      else            mv_store[i] = 8'(1 << $urandom_range(0, 7));
    end
  endtask

  task automatic handshake();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    send_resp   = 1'b1; tick(); send_resp   = 1'b0;
  endtask

  task automatic serve(input int idx, input bit last, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cmd_rdy) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL serve_timeout: cmd_rdy low for 20 cycles at move %0d", idx);
    end else begin
      chk("tour_idx", 32'(bus.mv_indx), 32'(idx));
      clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
      chk("wait_resp", 32'(bus.resp), last ? 32'h5A : 32'hA5);
      tick();
      send_resp = 1'b1; tick(); send_resp = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int n_served;

    rst = 1'b1; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_rdy_UART = 1'b0; cmd_UART = 16'hBEEF;
    for (int i = 0; i < 24; i++) mv_store[i] = 8'h01;
    tick(); tick();
    chk("rst_resp", 32'(bus.resp), 32'h5A);
    chk("rst_indx", 32'(bus.mv_indx), 32'd0);
    chk("rst_cmd", 32'(bus.cmd), 32'hBEEF);
    chk("rst_rdy", 32'(bus.cmd_rdy), 32'd0);
    rst = 1'b0;

    // Idle passthrough
    cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1; #1;
    chk("pass_cmd", 32'(bus.cmd), 32'h2000);
    chk("pass_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("pass_clr0", 32'(bus.clr_cmd_rdy_UART), 32'd0);
    clr_cmd_rdy = 1'b1; #1;
    chk("pass_clr1", 32'(bus.clr_cmd_rdy_UART), 32'd1);
    tick(); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
    chk("pass_clr2", 32'(bus.clr_cmd_rdy_UART), 32'd0);

    // Short tour: three moves then an empty slot aborts it
    mv_store[0] = 8'h01; mv_store[1] = 8'h10; mv_store[2] = 8'h40; mv_store[3] = 8'h00;
    cmd_UART = 16'h7777;
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("m0_v", 32'(bus.cmd), 32'h4002);
    chk("m0_v_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("m0_v_resp", 32'(bus.resp), 32'hA5);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("m0_wait_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("m0_wait_resp", 32'(bus.resp), 32'hA5);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("m0_h", 32'(bus.cmd), 32'h5BF1);
    handshake(); chk("m1_v", 32'(bus.cmd), 32'h47F2); chk("m1_idx", 32'(bus.mv_indx), 32'd1);
    handshake(); chk("m1_h", 32'(bus.cmd), 32'h53F1);
    handshake(); chk("m2_v", 32'(bus.cmd), 32'h47F1); chk("m2_idx", 32'(bus.mv_indx), 32'd2);
    handshake(); chk("m2_h", 32'(bus.cmd), 32'h5BF2);
    handshake();
    chk("abort_cmd", 32'(bus.cmd), 32'h7777);
    chk("abort_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("abort_resp", 32'(bus.resp), 32'h5A);

    // Empty first move: no command from the tour at all
    mv_store[0] = 8'h00;
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_rdy", 32'(bus.cmd_rdy), 32'd0);
      chk("empty_resp", 32'(bus.resp), 32'h5A);
      tick();
    end

    // Full 24-move tour
    for (int i = 0; i < 24; i++) mv_store[i] = 8'(1 << $urandom_range(0, 7));
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    n_served = 0;
    for (int i = 0; i < 24; i++) begin
      for (int h = 0; h < 2; h++) begin
        serve(i, (i == 23 && h == 1), ok);
        if (ok) n_served++;
      end
    end
    chk("tour_cmds", 32'(n_served), 32'd48);
    chk("tour_end_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("tour_end_resp", 32'(bus.resp), 32'h5A);

    // start_tour ignored mid-tour, then reset from HORZ
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("vw_start_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("vw_start_cmd", 32'(bus.cmd), 32'(exp_cmd(mv_store[0], 0)));
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("horz_rdy", 32'(bus.cmd_rdy), 32'd1);
    rst = 1'b1; cmd_UART = 16'h1234; tick(); rst = 1'b0;
    chk("mrst_cmd", 32'(bus.cmd), 32'h1234);
    chk("mrst_idx", 32'(bus.mv_indx), 32'd0);
    chk("mrst_resp", 32'(bus.resp), 32'h5A);
    chk("mrst_rdy", 32'(bus.cmd_rdy), 32'd0);

    // Randomized traffic against the model
    fill_random();
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 1499) == 0);
      start_tour   = ($urandom_range(0, 15) == 0);
      clr_cmd_rdy  = ($urandom_range(0, 2) == 0);
      send_resp    = ($urandom_range(0, 2) == 0);
      cmd_rdy_UART = 1'($urandom_range(0, 1));
      cmd_UART     = 16'($urandom);
      if (!m_active && $urandom_range(0, 3) == 0) fill_random();
      tick();
    end
    rst = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
